// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   SPI mode-0 (CPOL=0, CPHA=0) master, one 8-bit MSB-first full-duplex
//   transfer per accepted start request. SCK half-period = CLK_DIV clk_i cycles.
//   Frame: SETUP (CLK_DIV) + 16 SCK half-periods + HOLD (CLK_DIV) with SS low,
//   then GUARD (CLK_DIV) with SS high before the next start can be accepted.
//   Every output comes straight from a flop.
//
//   Optional build macro: SPI_MASTER_MISO_SYNC_EN
//     defined   -> MISO goes through a 2-flop synchronizer (CLK_DIV >= 4)
//     undefined -> MISO sampled directly               (CLK_DIV >= 2)
// -----------------------------------------------------------------------------
module spi_master #(
    parameter logic [7:0] CLK_DIV = 8'd4
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       start_i,
    input  logic [7:0] tx_data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rx_data_o,
    output logic       SS,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GUARD
    } state_t;

    // Last count of every phase; the counter reloads to zero on each phase change.
    localparam logic [7:0] TERM_CNT = CLK_DIV - 8'd1;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] half_q, half_d;       // SCK half-period index inside XFER
    logic [6:0] tx_q, tx_d;           // remaining bits; bit 7 already sits on MOSI
    logic [7:0] rx_q, rx_d;           // receive shifter
    logic       ss_d, sck_d, mosi_d, busy_d, done_d;
    logic [7:0] rx_data_d;
    logic       miso_s;               // MISO as seen by the receive shifter
    logic       term;

`ifdef SPI_MASTER_MISO_SYNC_EN
    logic miso_meta_q, miso_sync_q;

    // Two-flop synchronizer for an asynchronous MISO source.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= MISO;
            miso_sync_q <= miso_meta_q;
        end
    end

    assign miso_s = miso_sync_q;

    // The synchronizer delay must fit inside the SCK-low half-period.
    always_ff @(posedge clk_i) begin
        assert (CLK_DIV >= 8'd4)
            else $error("spi_master: CLK_DIV must be >= 4 when MISO sync is enabled");
    end
`else
    assign miso_s = MISO;

    // A half-period shorter than two cycles would break the SETUP/XFER timing.
    always_ff @(posedge clk_i) begin
        assert (CLK_DIV >= 8'd2)
            else $error("spi_master: CLK_DIV must be >= 2");
    end
`endif

    assign term = (cnt_q == TERM_CNT);

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        // NOTE: every variable gets a default first, so no branch can leave one
        // unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q + 8'd1;
        half_d    = half_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        ss_d      = SS;
        sck_d     = SCK;
        mosi_d    = MOSI;
        busy_d    = busy_o;
        done_d    = 1'b0;
        rx_data_d = rx_data_o;

        unique case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (start_i) begin
                    tx_d    = tx_data_i[6:0];
                    mosi_d  = tx_data_i[7];
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    half_d  = 4'd0;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                // First SCK rise: also the first MISO sample.
                if (term) begin
                    cnt_d   = 8'd0;
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[6:0], miso_s};
                    state_d = XFER;
                end
            end

            XFER: begin
                if (term) begin
                    cnt_d  = 8'd0;
                    half_d = half_q + 4'd1;
                    if (half_q == 4'd15) begin
                        // Low half-period after the 8th fall has elapsed.
                        state_d = HOLD;
                    end else if (SCK) begin
                        sck_d = 1'b0;
                        // The 8th fall leaves MOSI on bit 0.
                        if (half_q != 4'd14) begin
                            tx_d   = {tx_q[5:0], 1'b0};
                            mosi_d = tx_q[6];
                        end
                    end else begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[6:0], miso_s};
                    end
                end
            end

            HOLD: begin
                if (term) begin
                    cnt_d     = 8'd0;
                    ss_d      = 1'b1;
                    done_d    = 1'b1;
                    rx_data_d = rx_q;
                    state_d   = GUARD;
                end
            end

            GUARD: begin
                if (term) begin
                    cnt_d   = 8'd0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking assignments for all flops, so every register
            // samples the values from before this edge.
            state_q <= state_d;
        end
    end

    // Datapath and output registers; reset idles the bus at once.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q     <= 8'd0;
            half_q    <= 4'd0;
            tx_q      <= 7'd0;
            rx_q      <= 8'd0;
            SS        <= 1'b1;
            SCK       <= 1'b0;
            MOSI      <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            rx_data_o <= 8'h00;
        end else begin
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            SS        <= ss_d;
            SCK       <= sck_d;
            MOSI      <= mosi_d;
            busy_o    <= busy_d;
            done_o    <= done_d;
            rx_data_o <= rx_data_d;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//   Two spi_master instances: A with CLK_DIV=4, B with CLK_DIV=2 (5 when the
//   MISO synchronizer build is selected). A bus monitor with a behavioural
//   mode-0 slave records each frame; expected results come from the frame
//   rules (durations in multiples of CLK_DIV, byte exchange, loopback).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master;

    localparam int DIV_A = 4;
`ifdef SPI_MASTER_MISO_SYNC_EN
    localparam int DIV_B = 5;
`else
    localparam int DIV_B = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n [2];
    logic       start [2];
    logic [7:0] tx_d  [2];
    logic       busy  [2];
    logic       done  [2];
    logic [7:0] rx    [2];
    logic       ss    [2];
    logic       sck   [2];
    logic       mosi  [2];
    logic       miso  [2];

    // Bench-side state: slave model and frame measurements.
    logic       loop_en     [2];
    logic [7:0] slave_byte  [2];
    logic [7:0] slave_sh    [2];
    logic       miso_s      [2];
    logic [7:0] mosi_rec    [2];
    logic [15:0] rx_hist    [2];
    int rises [2], done_cnt [2], ss_fall_cnt [2];
    int ss_fall_cyc [2], ss_rise_cyc [2], ss_low_len [2], ss_gap [2];
    int done_cyc [2], busy_fall_cyc [2];
    logic prev_ss [2], prev_sck [2], prev_mosi [2], prev_busy [2];
    logic [7:0] prev_rx [2];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign miso[0] = loop_en[0] ? mosi[0] : miso_s[0];
    assign miso[1] = loop_en[1] ? mosi[1] : miso_s[1];

    spi_master #(.CLK_DIV(8'(DIV_A))) u_dut_a (
        .clk_i(clk), .reset_ni(rst_n[0]), .start_i(start[0]), .tx_data_i(tx_d[0]),
        .busy_o(busy[0]), .done_o(done[0]), .rx_data_o(rx[0]),
        .SS(ss[0]), .SCK(sck[0]), .MOSI(mosi[0]), .MISO(miso[0])
    );

    spi_master #(.CLK_DIV(8'(DIV_B))) u_dut_b (
        .clk_i(clk), .reset_ni(rst_n[1]), .start_i(start[1]), .tx_data_i(tx_d[1]),
        .busy_o(busy[1]), .done_o(done[1]), .rx_data_o(rx[1]),
        .SS(ss[1]), .SCK(sck[1]), .MOSI(mosi[1]), .MISO(miso[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Bus monitor and mode-0 slave, sampled on the falling clk edge.
    initial begin
        for (int u = 0; u < 2; u++) begin
            prev_ss[u] = 1'b1; prev_sck[u] = 1'b0; prev_mosi[u] = 1'b0;
            prev_busy[u] = 1'b0; prev_rx[u] = 8'h00;
            rises[u] = 0; done_cnt[u] = 0; ss_fall_cnt[u] = 0;
            ss_fall_cyc[u] = 0; ss_rise_cyc[u] = 0; ss_low_len[u] = 0; ss_gap[u] = 0;
            done_cyc[u] = 0; busy_fall_cyc[u] = 0;
            mosi_rec[u] = 8'h00; rx_hist[u] = 16'h0000;
            slave_byte[u] = 8'h00; slave_sh[u] = 8'h00; miso_s[u] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (prev_ss[u] && !ss[u]) begin
                    ss_fall_cnt[u]++;
                    ss_fall_cyc[u] = cyc;
                    ss_gap[u]      = cyc - ss_rise_cyc[u];
                    rises[u]       = 0;
                    mosi_rec[u]    = 8'h00;
                    slave_sh[u]    = slave_byte[u];
                    miso_s[u]      = slave_byte[u][7];
                end
                if (!prev_ss[u] && ss[u]) begin
                    ss_rise_cyc[u] = cyc;
                    ss_low_len[u]  = cyc - ss_fall_cyc[u];
                end
                if (!prev_sck[u] && sck[u]) begin
                    rises[u]++;
                    mosi_rec[u] = {mosi_rec[u][6:0], mosi[u]};
                end
                if (prev_sck[u] && !sck[u] && !ss[u]) begin
                    slave_sh[u] = {slave_sh[u][6:0], 1'b0};
                    miso_s[u]   = slave_sh[u][7];
                end
                if (!ss[u] && !prev_ss[u] && mosi[u] !== prev_mosi[u])
                    check("mosi_changes_only_at_sck_fall", {31'd0, prev_sck[u] && !sck[u]}, 32'd1);
                if (rst_n[u] && rx[u] !== prev_rx[u])
                    check("rx_changes_only_with_done", {31'd0, done[u]}, 32'd1);
                if (done[u]) begin
                    done_cnt[u]++;
                    done_cyc[u] = cyc;
                    rx_hist[u]  = {rx_hist[u][7:0], rx[u]};
                end
                if (prev_busy[u] && !busy[u]) busy_fall_cyc[u] = cyc;
                prev_ss[u] = ss[u]; prev_sck[u] = sck[u]; prev_mosi[u] = mosi[u];
                prev_busy[u] = busy[u]; prev_rx[u] = rx[u];
            end
        end
    end

    // One complete transfer with full frame checks.
    task automatic run_xfer(input int u, input logic [7:0] txb, input logic [7:0] sb,
                            input logic lb, input string tag);
        int d, n0, t0, g;
        logic [7:0] exp_rx;
        d      = (u == 0) ? DIV_A : DIV_B;
        exp_rx = lb ? txb : sb;
        loop_en[u]    = lb;
        slave_byte[u] = sb;
        g = 0;
        while (busy[u] && g < 1000) begin tick(); g++; end
        check({tag, "_idle_before_start"}, {31'd0, busy[u]}, 32'd0);
        n0 = done_cnt[u];
        tx_d[u] = txb; start[u] = 1'b1; t0 = cyc;
        tick();
        start[u] = 1'b0; tx_d[u] = 8'($urandom);
        check({tag, "_busy_after_accept"}, {31'd0, busy[u]}, 32'd1);
        g = 0;
        while (busy[u] && g < 30 * d + 20) begin tick(); g++; end
        check({tag, "_busy_released"}, {31'd0, busy[u]}, 32'd0);
        check({tag, "_done_pulses"}, done_cnt[u] - n0, 32'd1);
        check({tag, "_ss_fall_latency"}, ss_fall_cyc[u] - t0, 32'd1);
        check({tag, "_ss_low_cycles"}, ss_low_len[u], 18 * d);
        check({tag, "_done_time"}, done_cyc[u] - t0, 1 + 18 * d);
        check({tag, "_busy_fall_time"}, busy_fall_cyc[u] - t0, 1 + 19 * d);
        check({tag, "_sck_rises"}, rises[u], 32'd8);
        check({tag, "_slave_saw_mosi"}, {24'd0, mosi_rec[u]}, {24'd0, txb});
        check({tag, "_rx_data"}, {24'd0, rx[u]}, {24'd0, exp_rx});
    endtask

    initial begin : main
        int g, n0, f0;
        logic [7:0] b;
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; start[u] = 1'b0; tx_d[u] = 8'h00; loop_en[u] = 1'b1;
        end
        tick(); tick();
        for (int u = 0; u < 2; u++) begin
            check("reset_ss", {31'd0, ss[u]}, 32'd1);
            check("reset_sck", {31'd0, sck[u]}, 32'd0);
            check("reset_mosi", {31'd0, mosi[u]}, 32'd0);
            check("reset_busy", {31'd0, busy[u]}, 32'd0);
            check("reset_done", {31'd0, done[u]}, 32'd0);
            check("reset_rx", {24'd0, rx[u]}, 32'd0);
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        tick(); tick();

        // Directed loopback and slave-model frames.
        run_xfer(0, 8'hA5, 8'h00, 1'b1, "loopback_a5");
        run_xfer(0, 8'h3C, 8'hAA, 1'b0, "slave_3c_aa");
        run_xfer(0, 8'h5A, 8'h00, 1'b1, "loopback_5a");

        // Randomized frames on both instances.
        for (int i = 0; i < 10; i++)
            run_xfer(0, 8'($urandom), 8'($urandom), 1'($urandom), "rand_a");
        for (int i = 0; i < 4; i++)
            run_xfer(1, 8'($urandom), 8'($urandom), 1'($urandom), "rand_b");

        // Busy rejection: a second start mid-XFER must be ignored.
        loop_en[0] = 1'b0;
        b = 8'($urandom_range(1, 255));
        slave_byte[0] = b;
        n0 = done_cnt[0]; f0 = ss_fall_cnt[0];
        tx_d[0] = 8'h12; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        g = 0;
        while (rises[0] < 3 && g < 200) begin tick(); g++; end
        check("reject_reached_xfer", {31'd0, rises[0] >= 3}, 32'd1);
        tx_d[0] = 8'hFF; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        g = 0;
        while (busy[0] && g < 200) begin tick(); g++; end
        check("reject_busy_released", {31'd0, busy[0]}, 32'd0);
        repeat (40) tick();
        check("reject_sck_rises", rises[0], 32'd8);
        check("reject_mosi_pattern", {24'd0, mosi_rec[0]}, 32'h12);
        check("reject_rx", {24'd0, rx[0]}, {24'd0, b});
        check("reject_single_frame", ss_fall_cnt[0] - f0, 32'd1);
        check("reject_single_done", done_cnt[0] - n0, 32'd1);
        check("reject_stays_idle", {31'd0, busy[0]}, 32'd0);

        // Reset mid-transfer: bus idles asynchronously, partial byte is lost.
        n0 = done_cnt[0];
        slave_byte[0] = 8'($urandom);
        tx_d[0] = 8'($urandom); start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        g = 0;
        while (rises[0] < 4 && g < 200) begin tick(); g++; end
        check("abort_reached_4th_rise", {31'd0, rises[0] >= 4}, 32'd1);
        check("abort_rx_nonzero_before", {31'd0, rx[0] != 8'h00}, 32'd1);
        #2 rst_n[0] = 1'b0;
        #1;
        check("abort_ss_async", {31'd0, ss[0]}, 32'd1);
        check("abort_sck_async", {31'd0, sck[0]}, 32'd0);
        check("abort_mosi_async", {31'd0, mosi[0]}, 32'd0);
        check("abort_busy_async", {31'd0, busy[0]}, 32'd0);
        check("abort_rx_cleared", {24'd0, rx[0]}, 32'd0);
        tick();
        rst_n[0] = 1'b1;
        tick();
        check("abort_no_done", done_cnt[0] - n0, 32'd0);
        run_xfer(0, 8'($urandom), 8'($urandom), 1'b0, "after_reset");

        // Back-to-back on instance B with start held high.
        loop_en[1] = 1'b1;
        g = 0;
        while (busy[1] && g < 200) begin tick(); g++; end
        n0 = done_cnt[1]; f0 = ss_fall_cnt[1];
        tx_d[1] = 8'h01; start[1] = 1'b1;
        g = 0;
        while (ss_fall_cnt[1] == f0 && g < 20) begin tick(); g++; end
        check("b2b_first_accept", ss_fall_cnt[1] - f0, 32'd1);
        tx_d[1] = 8'h80;
        g = 0;
        while (ss_fall_cnt[1] == f0 + 1 && g < 25 * DIV_B + 20) begin tick(); g++; end
        check("b2b_second_accept", ss_fall_cnt[1] - f0, 32'd2);
        start[1] = 1'b0;
        g = 0;
        while (busy[1] && g < 25 * DIV_B + 20) begin tick(); g++; end
        check("b2b_busy_released", {31'd0, busy[1]}, 32'd0);
        check("b2b_done_count", done_cnt[1] - n0, 32'd2);
        check("b2b_ss_high_gap", ss_gap[1], DIV_B + 1);
        check("b2b_ss_low_cycles", ss_low_len[1], 18 * DIV_B);
        check("b2b_rx_sequence", {16'd0, rx_hist[1]}, 32'h0180);
        check("b2b_mosi_second", {24'd0, mosi_rec[1]}, 32'h80);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_master.md
# spi_master

SPI mode-0 (CPOL=0, CPHA=0) master that runs one 8-bit, MSB-first, full-duplex transfer per request. It drives SS/SCK/MOSI to an off-chip or on-chip SPI slave and captures MISO. SCK is generated from clk_i by a programmable divider. It is the initiator counterpart of the team's SPI slave and serves as its stimulus and bring-up partner.

## Interface
- CLK_DIV, 4, SCK half-period in clk_i cycles; legal range 2..255
- clk_i  input  1  system clock
- reset_ni  input  1  asynchronous, active-low reset
- start_i  input  1  transfer request, sampled on clk_i
- tx_data_i  input  8  byte to send, latched when start is accepted
- busy_o  output  1  transfer or guard interval in progress
- done_o  output  1  one-cycle pulse, transfer complete
- rx_data_o  output  8  last received byte
- SS  output  1  slave select, active low
- SCK  output  1  SPI clock, idle low
- MOSI  output  1  master out, registered
- MISO  input  1  master in

## Operation
- Reset: SS=1, SCK=0, MOSI=0, busy_o=0, done_o=0, rx_data_o=8'h00, FSM=IDLE. Reset is asynchronous, so SS rises and SCK falls immediately, including mid-transfer. The partial byte is discarded.
- All outputs are driven from flops. There are no combinational paths from inputs to outputs.
- States:
  - IDLE
  - SETUP
  - XFER
  - HOLD
  - GUARD
- IDLE:
  - start_i=1 is accepted.
  - tx_data_i is latched into the tx shifter.
  - Next cycle: SS=0, MOSI=tx[7], busy_o=1, state SETUP.
- SETUP: hold for CLK_DIV cycles with SCK=0, then drive SCK=1 and enter XFER.
- XFER: SCK toggles every CLK_DIV cycles.
  - Rising edge (the clk_i edge that drives SCK to 1): shift MISO (or synchronized MISO, see Configuration) into rx[0], shifting left.
  - Falling edge: shift the tx register left and drive MOSI from the new tx[7]. The 8th falling edge does not update MOSI.
  - After the 8th falling edge, enter HOLD.
- HOLD: CLK_DIV cycles with SCK=0 and SS=0. Then:
  - SS=1.
  - done_o=1 for exactly one cycle.
  - rx_data_o is updated in the same cycle.
  - state GUARD.
- GUARD: SS stays high for CLK_DIV cycles, then busy_o=0 and state IDLE.
- start_i is ignored whenever busy_o=1. There is no queuing.
- A start request is accepted only when busy_o=0.
- A start held high across the GUARD→IDLE boundary is accepted in the first IDLE cycle.
- tx_data_i is don't-care except in the accept cycle.
- The counter is 8 bits and reloads at every phase change. Its terminal count is CLK_DIV-1.
- rx_data_o holds its value between transfers and changes only with done_o.

## Timing
- Start accepted at edge 0. SS falls at edge 1.
- First SCK rise at edge 1+CLK_DIV.
- 16 SCK half-periods.
- SS low for exactly 18*CLK_DIV cycles.
- done_o at edge 1+18*CLK_DIV.
- busy_o falls CLK_DIV cycles after done_o.
- Minimum start-to-start spacing: 1+19*CLK_DIV cycles.
- MOSI is stable for at least CLK_DIV cycles before each SCK rise and changes only at SCK falls.

## Configuration
- SPI_MASTER_MISO_SYNC_EN
  - Defined:
    - MISO passes through a 2-flop synchronizer, reset to 0.
    - The rx shifter samples the synchronized value on the SCK-rising clk_i edge.
    - Sampled data therefore reflects MISO two cycles earlier.
    - CLK_DIV≥4 is required; a simulation assertion fires otherwise.
  - Undefined: MISO is sampled directly on the SCK-rising clk_i edge, and CLK_DIV≥2 applies.

## Test plan
- Loopback:
  - Stimulus: CLK_DIV=4, MOSI→MISO tied, start with tx_data_i=8'hA5.
  - Response: SS low 72 cycles, 8 SCK rises, done_o pulse at cycle 73, rx_data_o=8'hA5, busy_o low at cycle 77.
- Slave model:
  - Stimulus: behavioural mode-0 slave returning 8'hAA and recording MOSI; master sends 8'h3C.
  - Response: slave sees 8'h3C, rx_data_o=8'hAA, exactly one done_o pulse.
- Busy rejection:
  - Stimulus: start_i pulsed with 8'hFF in mid-XFER of a transfer of 8'h12.
  - Response: the 8'hFF start is ignored, SCK shows only 8 rises, MOSI pattern is 8'h12.
- Reset mid-transfer:
  - Stimulus: reset_ni low after the 4th SCK rise.
  - Response: SS=1, SCK=0, MOSI=0 asynchronously, rx_data_o=8'h00, and a new transfer after reset completes normally.
- Back-to-back:
  - Stimulus: start_i held high, tx 8'h01 then 8'h80, CLK_DIV=2.
  - Response: two transfers, SS high for exactly 3 cycles between them (1 done + 2 guard), rx matches loopback.
- Sync build:
  - Stimulus: SPI_MASTER_MISO_SYNC_EN, CLK_DIV=4, loopback with 8'h5A.
  - Response: rx_data_o=8'h5A, same cycle counts as the loopback test.
